// File: rtl/reverse_double_dabble.sv
// Multi-cycle BCD-to-binary converter (reverse double-dabble: shift right, then
// subtract 3 from every digit >= 8). One conversion in flight at a time.
module reverse_double_dabble #(
   parameter int unsigned DECIMAL_DIGITS = 5,
   parameter int unsigned OUTPUT_WIDTH   = 16
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_L,
   input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
   input  logic                          i_Start,
   output logic [OUTPUT_WIDTH-1:0]       o_Binary,
   output logic                          o_DV,
   output logic                          o_Error,
   output logic                          o_Overflow,
   output logic                          o_Busy
);

   localparam int unsigned BCD_W = DECIMAL_DIGITS * 4;
   localparam int unsigned CNT_W = $clog2(OUTPUT_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VALIDATE,
      S_SHIFT,
      S_SUB,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d;
   logic [OUTPUT_WIDTH-1:0] bin_q, bin_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic [OUTPUT_WIDTH-1:0] binary_q, binary_d;
   logic                    dv_q, dv_d;
   logic                    error_q, error_d;
   logic                    ovf_q, ovf_d;
   logic                    bad_digit;

   // State and datapath registers
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= S_IDLE;
         bcd_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         binary_q <= '0;
         dv_q     <= 1'b0;
         error_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcd_q    <= bcd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         binary_q <= binary_d;
         dv_q     <= dv_d;
         error_q  <= error_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      binary_d  = binary_q;
      dv_d      = 1'b0;
      error_d   = error_q;
      ovf_d     = ovf_q;
      bad_digit = 1'b0;

      for (int d = 0; d < int'(DECIMAL_DIGITS); d++) begin
         if (bcd_q[d*4 +: 4] > 4'd9) bad_digit = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               bcd_d   = i_BCD;
               bin_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_VALIDATE;
            end
         end
         S_VALIDATE: begin
            if (bad_digit) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // BCD LSB drops into the binary MSB; the pair acts as one vector
            bin_d = {bcd_q[0], bin_q[OUTPUT_WIDTH-1:1]};
            bcd_d = {1'b0, bcd_q[BCD_W-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(OUTPUT_WIDTH)) state_d = S_DONE;
            else                               state_d = S_SUB;
         end
         S_SUB: begin
            for (int d = 0; d < int'(DECIMAL_DIGITS); d++) begin
               if (bcd_q[d*4 +: 4] >= 4'd8) bcd_d[d*4 +: 4] = bcd_q[d*4 +: 4] - 4'd3;
            end
            state_d = S_SHIFT;
         end
         S_DONE: begin
            dv_d    = 1'b1;
            error_d = err_q;
            if (err_q) begin
               binary_d = '0;
               ovf_d    = 1'b0;
            end else begin
               binary_d = bin_q;
               ovf_d    = |bcd_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_Binary   = binary_q;
   assign o_DV       = dv_q;
   assign o_Error    = error_q;
   assign o_Overflow = ovf_q;
   assign o_Busy     = (state_q != S_IDLE);

endmodule
